// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests beat fetches, one access in flight, hit pulses one cycle after ACCESS.
// Latency >= 2 cycles per access; requesters hold requests until their hit, the RAM throttles via ramstate.
module mem_arbiter #(
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        halt,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        err,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_INSTR,
        S_DONE,
        S_HALTED
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] CNT_LAST   = 4'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_wr;
    logic [3:0] r_cnt;

    logic       w_in_access;
    logic       w_ok;
    logic       w_fail;

    assign w_in_access = (r_state == S_DATA) || (r_state == S_INSTR);
    assign w_ok        = (ramstate == RAM_ACCESS);
    assign w_fail      = !w_ok && ((ramstate == RAM_ERROR) || (r_cnt == CNT_LAST));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_wr     <= 1'b0;
            r_cnt    <= 4'd0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            err      <= 1'b0;
            halted   <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            iload    <= 32'd0;
            dload    <= 32'd0;
            ramaddr  <= 32'd0;
            ramstore <= 32'd0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // halt only parks once no data request is outstanding
                    if (dREN || dWEN) begin
                        r_state  <= S_DATA;
                        r_wr     <= dWEN;
                        r_cnt    <= 4'd0;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        ramREN   <= !dWEN;
                        ramWEN   <= dWEN;
                    end else if (halt) begin
                        r_state <= S_HALTED;
                        halted  <= 1'b1;
                    end else if (iREN) begin
                        r_state <= S_INSTR;
                        r_wr    <= 1'b0;
                        r_cnt   <= 4'd0;
                        ramaddr <= iaddr;
                        ramREN  <= 1'b1;
                        ramWEN  <= 1'b0;
                    end
                end
                S_DATA, S_INSTR: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_ok || w_fail) begin
                        r_state <= S_DONE;
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        err     <= w_fail;
                        if (r_state == S_INSTR) begin
                            ihit  <= 1'b1;
                            iload <= w_ok ? ramload : ERR_WORD;
                        end else begin
                            dhit <= 1'b1;
                            if (!r_wr) begin
                                dload <= w_ok ? ramload : ERR_WORD;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                    ramREN  <= 1'b0;
                    ramWEN  <= 1'b0;
                    halted  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    logic w_unused;
    assign w_unused = w_in_access;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected hits are queued at request time and checked when the hit appears.
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        halt;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        err;
    logic        halted;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
    localparam logic [31:0] ERRW  = 32'hBAD1BAD1;

    typedef struct packed {
        logic        is_d;
        logic [31:0] load;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    exp_t        ex;
    logic [31:0] m_dload;
    int          n_vec;
    int          n_err;

    mem_arbiter #(.TIMEOUT(15), .ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .halt(halt), .ramstate(ramstate), .ramload(ramload),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .err(err), .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task test_reset();
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; halt = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramstate = FREE; ramload = 0;
        m_dload = 32'd0;
        repeat (2) @(negedge CLK);
        n_vec++;
        if ({ihit, dhit, err, halted, ramREN, ramWEN} !== 6'd0) begin
            n_err++; $display("FAIL reset_ctl: got %b want 000000", {ihit, dhit, err, halted, ramREN, ramWEN});
        end
        n_vec++;
        if (iload !== 32'd0) begin n_err++; $display("FAIL reset_iload: got %h want 0", iload); end
        n_vec++;
        if (dload !== 32'd0) begin n_err++; $display("FAIL reset_dload: got %h want 0", dload); end
        n_vec++;
        if (ramaddr !== 32'd0) begin n_err++; $display("FAIL reset_ramaddr: got %h want 0", ramaddr); end
        n_vec++;
        if (ramstore !== 32'd0) begin n_err++; $display("FAIL reset_ramstore: got %h want 0", ramstore); end
        nRST = 1'b1;
    endtask

    task test_fetch();
        @(negedge CLK);
        sb.push_back({1'b0, 32'h2408000A, 1'b0});
        iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h2408000A;
        @(negedge CLK);
        n_vec++;
        if (!(ramREN === 1'b1 && ramWEN === 1'b0 && ramaddr === 32'h40 && ihit === 1'b0)) begin
            n_err++; $display("FAIL fetch_strobe: ren=%b wen=%b addr=%h ihit=%b want 1 0 00000040 0", ramREN, ramWEN, ramaddr, ihit);
        end
        @(negedge CLK);
        n_vec++;
        if (ihit === 1'b1 || dhit === 1'b1) begin
            ex = sb.pop_front();
            if (dhit !== ex.is_d || ihit === ex.is_d || err !== ex.e || (ex.is_d ? dload : iload) !== ex.load) begin
                n_err++; $display("FAIL fetch_sb: ihit=%b dhit=%b err=%b iload=%h dload=%h want is_d=%b err=%b load=%h", ihit, dhit, err, iload, dload, ex.is_d, ex.e, ex.load);
            end
        end else begin
            n_err++; $display("FAIL fetch_hit: ihit=%b want 1", ihit);
        end
        n_vec++;
        if (ramREN !== 1'b0) begin n_err++; $display("FAIL fetch_done_strobe: ren=%b want 0", ramREN); end
        iREN = 0; ramstate = FREE;
        @(negedge CLK);
        n_vec++;
        if (ihit !== 1'b0 || ramREN !== 1'b0) begin
            n_err++; $display("FAIL fetch_pulse: ihit=%b ren=%b want 0 0", ihit, ramREN);
        end
    endtask

    task test_priority();
        int t_d;
        int t_i;
        t_d = -1; t_i = -1;
        @(negedge CLK);
        sb.push_back({1'b1, 32'hDEADBEEF, 1'b0});
        sb.push_back({1'b0, 32'h8C090004, 1'b0});
        m_dload = 32'hDEADBEEF;
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                n_vec++;
                if (!(ramREN === 1'b1 && ramaddr === 32'h100)) begin
                    n_err++; $display("FAIL prio_first: ren=%b addr=%h want 1 00000100", ramREN, ramaddr);
                end
            end
            if (ihit === 1'b1 || dhit === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL prio_extra_hit: ihit=%b dhit=%b want none", ihit, dhit);
                end else begin
                    ex = sb.pop_front();
                    if (dhit !== ex.is_d || ihit === ex.is_d || err !== ex.e || (ex.is_d ? dload : iload) !== ex.load) begin
                        n_err++; $display("FAIL prio_sb: ihit=%b dhit=%b err=%b iload=%h dload=%h want is_d=%b err=%b load=%h", ihit, dhit, err, iload, dload, ex.is_d, ex.e, ex.load);
                    end
                end
                if (dhit === 1'b1) begin t_d = c; dREN = 0; ramload = 32'h8C090004; end
                if (ihit === 1'b1) begin t_i = c; iREN = 0; end
            end
            if (t_d >= 0 && t_i >= 0) break;
        end
        n_vec++;
        if (t_d < 0 || t_i < 0 || (t_i - t_d) < 3) begin
            n_err++; $display("FAIL prio_order: dhit_cyc=%0d ihit_cyc=%0d want data first, gap>=3", t_d, t_i);
        end
    endtask

    task test_write();
        @(negedge CLK);
        sb.push_back({1'b1, m_dload, 1'b0});
        dWEN = 1; daddr = 32'h200; dstore = 32'hCAFEF00D; ramstate = BUSY;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            n_vec++;
            if (!(ramWEN === 1'b1 && ramREN === 1'b0 && ramaddr === 32'h200 && ramstore === 32'hCAFEF00D && dhit === 1'b0)) begin
                n_err++; $display("FAIL write_strobe%0d: wen=%b ren=%b addr=%h store=%h dhit=%b", k, ramWEN, ramREN, ramaddr, ramstore, dhit);
            end
            if (k == 3) ramstate = ACCESS;
        end
        @(negedge CLK);
        n_vec++;
        if (dhit === 1'b1 && sb.size() != 0) begin
            ex = sb.pop_front();
            if (ihit === 1'b1 || err !== ex.e || dload !== ex.load || ramWEN !== 1'b0) begin
                n_err++; $display("FAIL write_sb: ihit=%b err=%b dload=%h wen=%b want 0 0 %h 0", ihit, err, dload, ramWEN, ex.load);
            end
        end else begin
            n_err++; $display("FAIL write_hit: dhit=%b want 1", dhit);
        end
        dWEN = 0; ramstate = FREE;
    endtask

    task test_timeout();
        int k;
        @(negedge CLK);
        sb.push_back({1'b1, ERRW, 1'b1});
        m_dload = ERRW;
        dREN = 1; daddr = 32'h300; ramstate = BUSY;
        @(negedge CLK);
        n_vec++;
        if (ramREN !== 1'b1) begin n_err++; $display("FAIL tmo_strobe: ren=%b want 1", ramREN); end
        k = 0;
        while (k < 40 && dhit !== 1'b1) begin
            @(negedge CLK);
            k++;
        end
        n_vec++;
        if (k != 15) begin n_err++; $display("FAIL tmo_cycles: hit after %0d cycles want 15", k); end
        n_vec++;
        if (dhit === 1'b1 && sb.size() != 0) begin
            ex = sb.pop_front();
            if (err !== ex.e || dload !== ex.load || ihit === 1'b1) begin
                n_err++; $display("FAIL tmo_sb: err=%b dload=%h ihit=%b want 1 %h 0", err, dload, ihit, ex.load);
            end
        end else begin
            n_err++; $display("FAIL tmo_hit: dhit=%b want 1", dhit);
        end
        dREN = 0; ramstate = FREE;
    endtask

    task test_error();
        @(negedge CLK);
        sb.push_back({1'b0, ERRW, 1'b1});
        iREN = 1; iaddr = 32'h48; ramstate = ERROR; ramload = 32'h12345678;
        repeat (2) @(negedge CLK);
        n_vec++;
        if (ihit === 1'b1 && sb.size() != 0) begin
            ex = sb.pop_front();
            if (err !== ex.e || iload !== ex.load || dhit === 1'b1 || dload !== m_dload) begin
                n_err++; $display("FAIL error_sb: err=%b iload=%h dhit=%b dload=%h want 1 %h 0 %h", err, iload, dhit, dload, ex.load, m_dload);
            end
        end else begin
            n_err++; $display("FAIL error_hit: ihit=%b want 1", ihit);
        end
        iREN = 0; ramstate = FREE;
        @(negedge CLK);
        n_vec++;
        if (err !== 1'b0 || ihit !== 1'b0) begin n_err++; $display("FAIL error_pulse: err=%b ihit=%b want 0 0", err, ihit); end
    endtask

    task test_halt();
        bit seen;
        bit ok;
        @(negedge CLK);
        sb.push_back({1'b1, 32'h11223344, 1'b0});
        m_dload = 32'h11223344;
        halt = 1; dREN = 1; daddr = 32'h80; ramstate = ACCESS; ramload = 32'h11223344;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLK);
            if (dhit === 1'b1) seen = 1;
        end
        n_vec++;
        if (seen && sb.size() != 0) begin
            ex = sb.pop_front();
            if (err !== ex.e || dload !== ex.load || halted !== 1'b0) begin
                n_err++; $display("FAIL halt_sb: err=%b dload=%h halted=%b want 0 %h 0", err, dload, halted, ex.load);
            end
        end else begin
            n_err++; $display("FAIL halt_data_hit: dhit never seen before parking");
        end
        dREN = 0;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge CLK);
            if (halted === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL halt_park: halted=%b want 1", halted); end
        iREN = 1; iaddr = 32'h60;
        ok = 1;
        repeat (10) begin
            @(negedge CLK);
            if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ihit !== 1'b0 || halted !== 1'b1) ok = 0;
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL halt_terminal: ren=%b wen=%b ihit=%b halted=%b want 0 0 0 1", ramREN, ramWEN, ihit, halted); end
        iREN = 0;
    endtask

    task test_async_reset();
        bit ok;
        nRST = 0; halt = 0;
        @(negedge CLK);
        n_vec++;
        if (halted !== 1'b0) begin n_err++; $display("FAIL arst_halted: halted=%b want 0", halted); end
        nRST = 1;
        @(negedge CLK);
        dREN = 1; daddr = 32'h400; ramstate = BUSY;
        @(negedge CLK);
        n_vec++;
        if (ramREN !== 1'b1) begin n_err++; $display("FAIL arst_pre: ren=%b want 1", ramREN); end
        #2 nRST = 0;
        #1;
        n_vec++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'd0) begin
            n_err++; $display("FAIL arst_drop: ren=%b wen=%b addr=%h want 0 0 0", ramREN, ramWEN, ramaddr);
        end
        dREN = 0; ramstate = ACCESS;
        @(negedge CLK);
        nRST = 1;
        ok = 1;
        repeat (3) begin
            @(negedge CLK);
            if (ihit !== 1'b0 || dhit !== 1'b0 || ramREN !== 1'b0) ok = 0;
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL arst_nohit: ihit=%b dhit=%b ren=%b want 0 0 0", ihit, dhit, ramREN); end
        sb.push_back({1'b0, 32'h0000ABCD, 1'b0});
        iREN = 1; iaddr = 32'h500; ramload = 32'h0000ABCD;
        @(negedge CLK);
        n_vec++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin n_err++; $display("FAIL arst_idle: ren=%b addr=%h want 1 00000500", ramREN, ramaddr); end
        @(negedge CLK);
        n_vec++;
        if (ihit === 1'b1 && sb.size() != 0) begin
            ex = sb.pop_front();
            if (iload !== ex.load || err !== ex.e || dhit === 1'b1) begin
                n_err++; $display("FAIL arst_sb: iload=%h err=%b dhit=%b want %h 0 0", iload, err, dhit, ex.load);
            end
        end else begin
            n_err++; $display("FAIL arst_hit: ihit=%b want 1", ihit);
        end
        iREN = 0;
        @(negedge CLK);
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d entries want 0", sb.size()); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_timeout();
        test_error();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
